fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage and the I-side memory.
// The fetch stage is the master: it raises imem_req with imem_addr and the
// memory answers with imem_ready/imem_rdata in the same cycle.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Three-state controller (IDLE / REQ / HOLD) issuing one read at a time to the
// instruction memory and presenting {IR_ID, PC_ID} to decode. When decode is
// stalled as a word arrives, the word is parked in a single-entry hold buffer
// and fetching pauses until decode drains it. A redirect flushes everything
// and restarts fetch at the (word-aligned) target. IR_ID = 0 means bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stallFlag,    // 1 = decode advances this cycle
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          IR_ID,
  output logic [31:0]          PC_ID,
  output logic                 fetch_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pcid_q, pcid_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic        xfer;
  logic [31:0] pc_inc;
  logic [31:0] redir_tgt;
  logic [31:0] reset_pc_al;

  // Low two bits of any PC source are forced to zero so PC stays word aligned.
  assign redir_tgt   = redirect_pc & ~32'h3;
  assign reset_pc_al = RESET_PC & ~32'h3;
  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
  assign pc_inc      = pc_q + 32'd4;

  // Memory-port outputs; gated by rst_n so nothing is requested during reset,
  // even before the reset edge has moved the state back to IDLE.
  assign imem.imem_req  = rst_n && (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign xfer           = imem.imem_req && imem.imem_ready;
  assign fetch_busy     = imem.imem_req && !imem.imem_ready;

  assign IR_ID = ir_q;
  assign PC_ID = pcid_q;

  // Next-state and datapath update: redirect beats any transfer or stall.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pcid_d    = pcid_q;
    hold_ir_d = hold_ir_q;
    hold_pc_d = hold_pc_q;

    unique case (state_q)
      S_IDLE: begin
        // One dead cycle before the first request; a redirect still steers PC.
        state_d = S_REQ;
        if (redirect) pc_d = redir_tgt;
      end

      S_REQ: begin
        if (redirect) begin
          // Flush: any word returned this cycle belongs to the wrong path.
          pc_d      = redir_tgt;
          ir_d      = 32'h0;
          pcid_d    = 32'h0;
          hold_ir_d = 32'h0;
          hold_pc_d = 32'h0;
          state_d   = S_REQ;
        end else if (xfer) begin
          pc_d = pc_inc;
          if (stallFlag) begin
            ir_d   = imem.imem_rdata;
            pcid_d = pc_inc;
          end else begin
            // Decode is blocked: park the word and stop fetching.
            hold_ir_d = imem.imem_rdata;
            hold_pc_d = pc_inc;
            state_d   = S_HOLD;
          end
        end else if (stallFlag) begin
          // Decode moved on but nothing arrived: feed it a bubble.
          ir_d   = 32'h0;
          pcid_d = 32'h0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d      = redir_tgt;
          ir_d      = 32'h0;
          pcid_d    = 32'h0;
          hold_ir_d = 32'h0;
          hold_pc_d = 32'h0;
          state_d   = S_REQ;
        end else if (stallFlag) begin
          // Decode accepts the parked word; PC already points past it.
          ir_d      = hold_ir_q;
          pcid_d    = hold_pc_q;
          hold_ir_d = 32'h0;
          hold_pc_d = 32'h0;
          state_d   = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= reset_pc_al;
      ir_q      <= 32'h0;
      pcid_q    <= 32'h0;
      hold_ir_q <= 32'h0;
      hold_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pcid_q    <= pcid_d;
      hold_ir_q <= hold_ir_d;
      hold_pc_q <= hold_pc_d;
    end
  end

`ifndef SYNTHESIS
  // Structural invariants: aligned PC, no request while a word is parked.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (pc_q[1:0] == 2'b00);
      assert (!(state_q == S_HOLD && imem.imem_req));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a long randomized run,
// all checked against a program-order reference model (fetch pointer plus a
// queue of fetched-but-undelivered instructions).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallFlag;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] IR_ID;
  logic [31:0] PC_ID;
  logic        fetch_busy;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stallFlag   (stallFlag),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .IR_ID       (IR_ID),
    .PC_ID       (PC_ID),
    .fetch_busy  (fetch_busy)
  );

  always #5 clk = ~clk;

  // Memory image: word = its own address, except one distinctive word at 0x10.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'h8C01_0004 : a;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: next fetch address, what decode currently sees, and the
  // instructions fetched but not yet handed to decode (at most one).
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_ir   = 32'h0;
  logic [31:0] m_pcid = 32'h0;
  logic        m_warm = 1'b0;
  logic [63:0] m_pend[$];

  task automatic model_edge();
    logic [31:0] w;
    if (!rst_n) begin
      m_pc = 32'h0; m_ir = 32'h0; m_pcid = 32'h0; m_warm = 1'b0;
      m_pend.delete();
    end else if (!m_warm) begin
      m_warm = 1'b1;
      if (redirect) m_pc = redirect_pc & ~32'h3;
    end else if (redirect) begin
      m_pc = redirect_pc & ~32'h3; m_ir = 32'h0; m_pcid = 32'h0;
      m_pend.delete();
    end else if (m_pend.size() != 0) begin
      if (stallFlag) {m_ir, m_pcid} = m_pend.pop_front();
    end else if (bus.imem_ready) begin
      w = mem_word(m_pc);
      if (stallFlag) begin
        m_ir = w; m_pcid = m_pc + 32'd4;
      end else begin
        m_pend.push_back({w, m_pc + 32'd4});
      end
      m_pc = m_pc + 32'd4;
    end else if (stallFlag) begin
      m_ir = 32'h0; m_pcid = 32'h0;
    end
  endtask

  // Advance one clock: model and DUT see the same inputs; return at negedge.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stallFlag = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_1234;
    bus.imem_ready = 1'b1;
    #1;
    chk_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.imem_req); else pass_cnt++;
    chk_cnt++; if (fetch_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", fetch_busy); else pass_cnt++;
    cyc();
    redirect = 1'b0;
    cyc();
    chk_cnt++; if (IR_ID !== 32'h0) $display("FAIL rst_ir got %h want 0", IR_ID); else pass_cnt++;
    chk_cnt++; if (PC_ID !== 32'h0) $display("FAIL rst_pcid got %h want 0", PC_ID); else pass_cnt++;
    chk_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req2 got %b want 0", bus.imem_req); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] e_ir, e_pcid;
    rst_n = 1'b1; stallFlag = 1'b1; bus.imem_ready = 1'b1;
    #1;
    chk_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", bus.imem_req); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      e_ir   = (k == 0) ? 32'h0 : 32'(k - 1) * 32'd4;
      e_pcid = (k == 0) ? 32'h0 : 32'(k) * 32'd4;
      chk_cnt++; if (IR_ID !== e_ir) $display("FAIL stream_ir[%0d] got %h want %h", k, IR_ID, e_ir); else pass_cnt++;
      chk_cnt++; if (PC_ID !== e_pcid) $display("FAIL stream_pcid[%0d] got %h want %h", k, PC_ID, e_pcid); else pass_cnt++;
      chk_cnt++; if (bus.imem_addr !== 32'(k) * 32'd4) $display("FAIL stream_addr[%0d] got %h want %h", k, bus.imem_addr, 32'(k) * 32'd4); else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    cyc();  // delivers 0xC, PC now 0x10
    stallFlag = 1'b0;
    #1;
    chk_cnt++; if (bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) $display("FAIL hold_pre addr %h req %b want 10/1", bus.imem_addr, bus.imem_req); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_cnt++; if (IR_ID !== 32'hC || PC_ID !== 32'h10) $display("FAIL hold_keep[%0d] ir %h pcid %h want c/10", i, IR_ID, PC_ID); else pass_cnt++;
      chk_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL hold_req[%0d] got %b want 0", i, bus.imem_req); else pass_cnt++;
    end
    stallFlag = 1'b1;
    cyc();
    chk_cnt++; if (IR_ID !== 32'h8C01_0004) $display("FAIL hold_rel_ir got %h want 8c010004", IR_ID); else pass_cnt++;
    chk_cnt++; if (PC_ID !== 32'h14) $display("FAIL hold_rel_pcid got %h want 14", PC_ID); else pass_cnt++;
    chk_cnt++; if (bus.imem_addr !== 32'h14 || bus.imem_req !== 1'b1) $display("FAIL hold_next addr %h req %b want 14/1", bus.imem_addr, bus.imem_req); else pass_cnt++;
  endtask

  task automatic test_not_ready();
    bus.imem_ready = 1'b0; stallFlag = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_cnt++; if (fetch_busy !== 1'b1) $display("FAIL nr_busy[%0d] got %b want 1", i, fetch_busy); else pass_cnt++;
      chk_cnt++; if (bus.imem_addr !== 32'h14) $display("FAIL nr_addr[%0d] got %h want 14", i, bus.imem_addr); else pass_cnt++;
      cyc();
      chk_cnt++; if (IR_ID !== 32'h0 || PC_ID !== 32'h0) $display("FAIL nr_bubble[%0d] ir %h pcid %h want 0/0", i, IR_ID, PC_ID); else pass_cnt++;
    end
    bus.imem_ready = 1'b1;
    #1;
    chk_cnt++; if (fetch_busy !== 1'b0) $display("FAIL nr_busy_end got %b want 0", fetch_busy); else pass_cnt++;
    cyc();
    chk_cnt++; if (IR_ID !== 32'h14 || PC_ID !== 32'h18) $display("FAIL nr_after ir %h pcid %h want 14/18", IR_ID, PC_ID); else pass_cnt++;
  endtask

  task automatic test_redirect();
    stallFlag = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0043; bus.imem_ready = 1'b1;
    cyc();
    chk_cnt++; if (IR_ID !== 32'h0 || PC_ID !== 32'h0) $display("FAIL redir_flush ir %h pcid %h want 0/0", IR_ID, PC_ID); else pass_cnt++;
    chk_cnt++; if (bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) $display("FAIL redir_addr addr %h req %b want 40/1", bus.imem_addr, bus.imem_req); else pass_cnt++;
    redirect = 1'b0; stallFlag = 1'b1;
    cyc();
    chk_cnt++; if (IR_ID !== 32'h40 || PC_ID !== 32'h44) $display("FAIL redir_next ir %h pcid %h want 40/44", IR_ID, PC_ID); else pass_cnt++;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; stallFlag = 1'b1;
    cyc();
    chk_cnt++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", bus.imem_addr); else pass_cnt++;
    redirect = 1'b0;
    cyc();
    chk_cnt++; if (IR_ID !== 32'hFFFF_FFFC || PC_ID !== 32'h0) $display("FAIL wrap_out ir %h pcid %h want fffffffc/0", IR_ID, PC_ID); else pass_cnt++;
    chk_cnt++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_next got %h want 0", bus.imem_addr); else pass_cnt++;
  endtask

  task automatic test_reset_in_hold();
    stallFlag = 1'b0;
    cyc();  // word at 0x0 parked
    chk_cnt++; if (bus.imem_req !== 1'b0 || IR_ID !== 32'hFFFF_FFFC) $display("FAIL rih_hold req %b ir %h want 0/fffffffc", bus.imem_req, IR_ID); else pass_cnt++;
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0800; stallFlag = 1'b1;
    #1;
    chk_cnt++; if (bus.imem_req !== 1'b0 || fetch_busy !== 1'b0) $display("FAIL rih_inrst req %b busy %b want 0/0", bus.imem_req, fetch_busy); else pass_cnt++;
    cyc();
    chk_cnt++; if (IR_ID !== 32'h0 || PC_ID !== 32'h0 || bus.imem_req !== 1'b0) $display("FAIL rih_clear ir %h pcid %h req %b want 0/0/0", IR_ID, PC_ID, bus.imem_req); else pass_cnt++;
    rst_n = 1'b1; redirect = 1'b0;
    #1;
    chk_cnt++; if (bus.imem_req !== 1'b0) $display("FAIL rih_idle got %b want 0", bus.imem_req); else pass_cnt++;
    cyc();
    chk_cnt++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL rih_restart req %b addr %h want 1/0", bus.imem_req, bus.imem_addr); else pass_cnt++;
  endtask

  task automatic test_random();
    logic e_req;
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      stallFlag      = ($urandom_range(0, 3) != 0);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      redirect       = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      #1;
      e_req = rst_n && m_warm && (m_pend.size() == 0);
      chk_cnt++; if (bus.imem_req !== e_req) $display("FAIL rnd_req[%0d] got %b want %b", n, bus.imem_req, e_req); else pass_cnt++;
      chk_cnt++; if (fetch_busy !== (e_req && !bus.imem_ready)) $display("FAIL rnd_busy[%0d] got %b want %b", n, fetch_busy, e_req && !bus.imem_ready); else pass_cnt++;
      if (e_req) begin
        chk_cnt++; if (bus.imem_addr !== m_pc) $display("FAIL rnd_addr[%0d] got %h want %h", n, bus.imem_addr, m_pc); else pass_cnt++;
      end
      chk_cnt++; if (IR_ID !== m_ir) $display("FAIL rnd_ir[%0d] got %h want %h", n, IR_ID, m_ir); else pass_cnt++;
      chk_cnt++; if (PC_ID !== m_pcid) $display("FAIL rnd_pcid[%0d] got %h want %h", n, PC_ID, m_pcid); else pass_cnt++;
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0; stallFlag = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold();
    test_not_ready();
    test_redirect();
    test_wrap();
    test_reset_in_hold();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
